// File: rtl/jtbubl_pkg.sv
// Shared constants and helpers for the jtbubl video stages.
// Palette geometry, background index and the packed pixel type.
package jtbubl_pkg;

  localparam int         BUBL_PAL_AW = 8;
  localparam logic [7:0] BUBL_BG_IDX = 8'hFF;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Even byte carries {R,G}; only the high nibble of the odd byte is colour.
  function automatic rgb_t pal_to_rgb(input logic [7:0] rg, input logic [3:0] b_hi);
    rgb_t px;
    px.r = rg[7:4];
    px.g = rg[3:0];
    px.b = b_hi;
    return px;
  endfunction

endpackage

// File: rtl/jtbubl_blank_dly.sv
// pxl_cen shift register for blanking signals, DLY ticks deep.
// pre exposes the value that the last stage will take on the next tick.
module jtbubl_blank_dly #(
  parameter int DLY = 2,
  parameter int W   = 2
) (
  input  logic         rst,
  input  logic         clk,
  input  logic         cen,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [W-1:0] pre
);

  logic [DLY-1:0][W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (cen) begin
      sr_d[0] = din;
      for (int i = 1; i < DLY; i++) sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign dout = sr_q[DLY-1];

  generate
    if (DLY > 1) begin : g_pre_sr
      assign pre = sr_q[DLY-2];
    end else begin : g_pre_in
      assign pre = din;
    end
  endgenerate

endmodule

// File: rtl/jtframe_dual_ram.sv
// Dual-clock RAM: port 0 read/write, port 1 read-only; both reads registered.
// One clock of read latency on each port; no backpressure.
module jtframe_dual_ram #(
  parameter int dw = 8,
  parameter int aw = 8
) (
  input  logic          clk0,
  input  logic [dw-1:0] data0,
  input  logic [aw-1:0] addr0,
  input  logic          we0,
  output logic [dw-1:0] q0,
  input  logic          clk1,
  input  logic [aw-1:0] addr1,
  output logic [dw-1:0] q1
);

  logic [dw-1:0] mem [0:(2**aw)-1];

  always_ff @(posedge clk0) begin
    if (we0) mem[addr0] <= data0;
    q0 <= mem[addr0];
  end

  always_ff @(posedge clk1) begin
    q1 <= mem[addr1];
  end

endmodule

// File: rtl/jtbubl_colmix.sv
// Final colour stage: palette lookup of the line-buffer index, blank gating and
// blank delay. Pixel side advances on pxl_cen only; CPU port writes on clk24.
module jtbubl_colmix
  import jtbubl_pkg::*;
#(
  parameter int BLANK_DLY = 2,
  parameter     SIMFILE   = "pal.hex"
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       clk24,
  input  logic       pxl_cen,
  input  logic       LHBL,
  input  logic       LVBL,
  input  logic [7:0] col_addr,
  input  logic       gfx_en,
  input  logic       pal_cs,
  input  logic       cpu_rnw,
  input  logic [8:0] cpu_addr,
  input  logic [7:0] cpu_dout,
  output logic [7:0] pal_dout,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       LHBL_dly,
  output logic       LVBL_dly
);

  // Palette preload is a simulation-model concern; the synthesizable RAM has none.
  localparam unused_simfile = SIMFILE;

  logic [BUBL_PAL_AW-1:0] idx_q, idx_d;
  rgb_t                   rgb_q, rgb_d;
  logic [7:0]             pal_dout_q, pal_dout_d;
  logic [7:0]             rg_pxl, b_pxl, rg_cpu, b_cpu;
  logic                   we_rg, we_b;
  logic [1:0]             blank_dly, blank_pre;
  logic                   blank_gate;
  logic [3:0]             unused_b_lo;

  assign we_rg = pal_cs & ~cpu_rnw & ~cpu_addr[0];
  assign we_b  = pal_cs & ~cpu_rnw &  cpu_addr[0];

  // The pixel port is addressed with the next index, so its registered output
  // always reflects the entry held in idx_q one clk later, ready for S1.
  jtframe_dual_ram #(.dw(8), .aw(BUBL_PAL_AW)) u_ram_rg (
    .clk0  (clk24),
    .data0 (cpu_dout),
    .addr0 (cpu_addr[8:1]),
    .we0   (we_rg),
    .q0    (rg_cpu),
    .clk1  (clk),
    .addr1 (idx_d),
    .q1    (rg_pxl)
  );

  jtframe_dual_ram #(.dw(8), .aw(BUBL_PAL_AW)) u_ram_b (
    .clk0  (clk24),
    .data0 (cpu_dout),
    .addr0 (cpu_addr[8:1]),
    .we0   (we_b),
    .q0    (b_cpu),
    .clk1  (clk),
    .addr1 (idx_d),
    .q1    (b_pxl)
  );

  assign unused_b_lo = b_pxl[3:0];

  jtbubl_blank_dly #(.DLY(BLANK_DLY), .W(2)) u_blank_dly (
    .rst  (rst),
    .clk  (clk),
    .cen  (pxl_cen),
    .din  ({LHBL, LVBL}),
    .dout (blank_dly),
    .pre  (blank_pre)
  );

  assign blank_gate = &blank_pre;

  always_comb begin
    idx_d = idx_q;
    rgb_d = rgb_q;
    if (pxl_cen) begin
      idx_d = gfx_en ? col_addr : BUBL_BG_IDX;
      rgb_d = blank_gate ? pal_to_rgb(rg_pxl, b_pxl[7:4]) : '0;
    end
  end

  always_comb begin
    pal_dout_d = 8'hFF;
    if (pal_cs) pal_dout_d = cpu_addr[0] ? b_cpu : rg_cpu;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= BUBL_BG_IDX;
      rgb_q      <= '0;
      pal_dout_q <= 8'hFF;
    end else begin
      idx_q      <= idx_d;
      rgb_q      <= rgb_d;
      pal_dout_q <= pal_dout_d;
    end
  end

  assign red      = rgb_q.r;
  assign green    = rgb_q.g;
  assign blue     = rgb_q.b;
  assign LHBL_dly = blank_dly[1];
  assign LVBL_dly = blank_dly[0];
  assign pal_dout = pal_dout_q;

endmodule

// File: tb/tb_jtbubl_colmix.sv
// Bench for jtbubl_colmix: sample-history model of the pixel path plus
// hand-computed literal expectations for the listed scenarios.
module tb_jtbubl_colmix;

  logic       rst = 1'b0;
  logic       clk = 1'b0;
  logic       clk24 = 1'b0;
  logic       pxl_cen = 1'b0;
  logic       LHBL = 1'b0;
  logic       LVBL = 1'b0;
  logic [7:0] col_addr = 8'h00;
  logic       gfx_en = 1'b1;
  logic       pal_cs = 1'b0;
  logic       cpu_rnw = 1'b1;
  logic [8:0] cpu_addr = 9'h000;
  logic [7:0] cpu_dout = 8'h00;
  logic [7:0] pal_dout;
  logic [3:0] red, green, blue;
  logic       LHBL_dly, LVBL_dly;

  int n_chk = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  jtbubl_colmix #(.BLANK_DLY(2)) dut (
    .rst(rst), .clk(clk), .clk24(clk24), .pxl_cen(pxl_cen),
    .LHBL(LHBL), .LVBL(LVBL), .col_addr(col_addr), .gfx_en(gfx_en),
    .pal_cs(pal_cs), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .pal_dout(pal_dout), .red(red), .green(green), .blue(blue),
    .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
  );

  always #5 clk = ~clk;
  always #4 clk24 = ~clk24;

  // Model: palette image as the CPU wrote it, and the last two pxl_cen samples.
  logic [7:0] m_rg [256];
  logic [7:0] m_b  [256];
  logic [7:0] h_idx [2];
  logic       h_hb  [2];
  logic       h_vb  [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      h_hb[0] <= 1'b0; h_hb[1] <= 1'b0;
      h_vb[0] <= 1'b0; h_vb[1] <= 1'b0;
      h_idx[0] <= 8'hFF; h_idx[1] <= 8'hFF;
    end else if (pxl_cen) begin
      h_idx[0] <= gfx_en ? col_addr : 8'hFF;
      h_hb[0]  <= LHBL;
      h_vb[0]  <= LVBL;
      h_idx[1] <= h_idx[0];
      h_hb[1]  <= h_hb[0];
      h_vb[1]  <= h_vb[0];
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs reflect the sample taken one tick before the most recent one.
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      logic [11:0] exp_rgb;
      exp_rgb = (h_hb[1] && h_vb[1]) ? {m_rg[h_idx[1]], m_b[h_idx[1]][7:4]} : 12'h000;
      check("model_rgb", {4'h0, red, green, blue}, {4'h0, exp_rgb});
      check("model_blank", {14'h0, LHBL_dly, LVBL_dly}, {14'h0, h_hb[1], h_vb[1]});
    end
  end

  task automatic cpu_write(input logic [8:0] a, input logic [7:0] d);
    chk_en = 1'b0;
    @(negedge clk24);
    pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = a; cpu_dout = d;
    @(negedge clk24);
    pal_cs = 1'b0; cpu_rnw = 1'b1;
    if (a[0]) m_b[a[8:1]] = d;
    else      m_rg[a[8:1]] = d;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
  endtask

  task automatic cpu_read(input logic [8:0] a, input logic [7:0] exp, input string name);
    @(negedge clk24);
    pal_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = a;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(name, {8'h0, pal_dout}, {8'h0, exp});
  endtask

  task automatic ticks(input int n);
    pxl_cen = 1'b1;
    repeat (n) @(negedge clk);
    pxl_cen = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin m_rg[i] = 8'h00; m_b[i] = 8'h00; end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rgb", {4'h0, red, green, blue}, 16'h0000);
    check("reset_blank", {14'h0, LHBL_dly, LVBL_dly}, 16'h0000);
    check("reset_pal_dout", {8'h0, pal_dout}, 16'h00FF);
    rst = 1'b0;

    cpu_write(9'h1A5, 8'hC3);
    cpu_write(9'h1A4, 8'h9E);
    cpu_write(9'h1FE, 8'h56);
    cpu_write(9'h1FF, 8'h70);
    for (int i = 0; i < 8; i++) begin
      cpu_write({1'b0, 8'h10 + 8'(i), 1'b0}, 8'h17 * 8'(i + 1));
      cpu_write({1'b0, 8'h10 + 8'(i), 1'b1}, {4'(i + 3), 4'hA});
    end
    settle();

    cpu_read(9'h1A4, 8'h9E, "cpu_read_rg");
    cpu_read(9'h1A5, 8'hC3, "cpu_read_b");
    @(negedge clk24);
    pal_cs = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("cpu_read_no_cs", {8'h0, pal_dout}, 16'h00FF);

    // First colour after blanks rise: {9,E,C} two ticks after D2 is presented.
    @(negedge clk);
    col_addr = 8'hD2; LHBL = 1'b1; LVBL = 1'b1;
    ticks(1);
    check("first_tick_blank", {4'h0, red, green, blue}, 16'h0000);
    ticks(1);
    check("pixel_9EC", {4'h0, red, green, blue}, 16'h09EC);
    ticks(2);

    LHBL = 1'b0;
    ticks(1);
    check("lhbl_fall_t1_dly", {15'h0, LHBL_dly}, 16'h0001);
    check("lhbl_fall_t1_rgb", {4'h0, red, green, blue}, 16'h09EC);
    ticks(1);
    check("lhbl_fall_t2_dly", {15'h0, LHBL_dly}, 16'h0000);
    check("lhbl_fall_t2_rgb", {4'h0, red, green, blue}, 16'h0000);
    LHBL = 1'b1;
    ticks(2);

    gfx_en = 1'b0;
    ticks(2);
    check("gfx_off_D2", {4'h0, red, green, blue}, 16'h0567);
    col_addr = 8'h13;
    ticks(2);
    check("gfx_off_13", {4'h0, red, green, blue}, 16'h0567);
    gfx_en = 1'b1;
    col_addr = 8'hD2;
    ticks(2);

    // pxl_cen idle: inputs wander, outputs must stay put.
    for (int i = 0; i < 3; i++) begin
      col_addr = 8'h10 + 8'(i);
      LHBL = i[0];
      @(negedge clk);
      check("hold_rgb", {4'h0, red, green, blue}, 16'h09EC);
      check("hold_blank", {14'h0, LHBL_dly, LVBL_dly}, 16'h0003);
    end
    LHBL = 1'b1;

    // Streamed entries, cen every other clk, with a vertical blank burst.
    for (int i = 0; i < 16; i++) begin
      col_addr = 8'h10 + 8'(i % 8);
      LVBL = !(i >= 9 && i <= 11);
      ticks(1);
      @(negedge clk);
    end
    LVBL = 1'b1;
    col_addr = 8'h12;
    ticks(2);
    check("entry_12", {4'h0, red, green, blue}, 16'h0455);

    col_addr = 8'hD2;
    ticks(2);
    rst = 1'b1;
    #1;
    check("midreset_rgb", {4'h0, red, green, blue}, 16'h0000);
    check("midreset_blank", {14'h0, LHBL_dly, LVBL_dly}, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ticks(1);
    check("post_reset_t1", {4'h0, red, green, blue}, 16'h0000);
    ticks(1);
    check("post_reset_t2", {4'h0, red, green, blue}, 16'h09EC);
    check("post_reset_blank", {14'h0, LHBL_dly, LVBL_dly}, 16'h0003);
    ticks(3);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
